// File: rtl/alu_pkg.sv
// alu_pkg: shared types and constants for the ALU result serializer.
// Optional feature macro: ALU_SER_CHECKSUM_EN (adds an XOR checksum byte B3).
package alu_pkg;

   localparam int ALU_RES_W = 18;

`ifdef ALU_SER_CHECKSUM_EN
   localparam int ALU_FRAME_BYTES = 4;
`else
   localparam int ALU_FRAME_BYTES = 3;
`endif

   localparam int ALU_CNT_W = 2;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } ser_state_t;

   // Holding register layout: carry above the 18-bit result.
   typedef struct packed {
      logic                 carry;
      logic [ALU_RES_W-1:0] res;
   } res_frame_t;

endpackage

// File: rtl/alu_result_serializer_if.sv
// alu_result_serializer_if: ALU result handshake plus the outgoing byte stream.
// Handshake rule for both channels: a transfer happens on a rising clk edge
// where valid && ready; the producer holds valid and payload until then.
// master = ALU / pad-mux side, slave = serializer.
interface alu_result_serializer_if;
   import alu_pkg::*;

   logic                 res_valid;
   logic                 res_ready;
   logic [ALU_RES_W-1:0] res_q;
   logic                 carry_q;
   logic                 out_valid;
   logic                 out_ready;
   logic [7:0]           out_data;
   logic                 out_last;
   logic                 busy;

   modport master (
      output res_valid, res_q, carry_q, out_ready,
      input  res_ready, out_valid, out_data, out_last, busy
   );

   modport slave (
      input  res_valid, res_q, carry_q, out_ready,
      output res_ready, out_valid, out_data, out_last, busy
   );

endinterface

// File: rtl/alu_res_byte_sel.sv
// alu_res_byte_sel: picks the frame byte for the current counter position.
// With ALU_SER_CHECKSUM_EN the fourth position is B0^B1^B2, independent of order.
module alu_res_byte_sel
   import alu_pkg::*;
#(
   parameter bit LSB_FIRST = 1'b1
) (
   input  res_frame_t           hold_i,
   input  logic [ALU_CNT_W-1:0] cnt_i,
   output logic [7:0]           byte_o
);

   logic [7:0]           b0;
   logic [7:0]           b1;
   logic [7:0]           b2;
   logic [ALU_CNT_W-1:0] pos;

   assign b0 = hold_i.res[7:0];
   assign b1 = hold_i.res[15:8];
   assign b2 = {5'b00000, hold_i.carry, hold_i.res[17:16]};

   // Map counter to data byte index; MSB-first order mirrors only the data bytes.
   always_comb begin
      pos    = cnt_i;
      byte_o = 8'h00;
      if (!LSB_FIRST && (cnt_i <= 2'd2)) begin
         pos = 2'd2 - cnt_i;
      end
      case (pos)
         2'd0:    byte_o = b0;
         2'd1:    byte_o = b1;
         2'd2:    byte_o = b2;
`ifdef ALU_SER_CHECKSUM_EN
         default: byte_o = b0 ^ b1 ^ b2;
`else
         default: byte_o = 8'h00;
`endif
      endcase
   end

endmodule

// File: rtl/alu_result_serializer.sv
// alu_result_serializer: captures one ALU result per handshake and streams it
// as a 3-byte frame (4 with ALU_SER_CHECKSUM_EN) on an 8-bit valid/ready bus.
// res_ready depends combinationally on out_ready so the next result can be
// captured on the last-byte cycle, giving gap-free back-to-back frames.
module alu_result_serializer
   import alu_pkg::*;
#(
   parameter bit LSB_FIRST = 1'b1
) (
   input  logic                          clk,
   input  logic                          rst,
   alu_result_serializer_if.slave        ser_if,
   output ser_state_t                    dbg_state_o
);

   localparam logic [ALU_CNT_W-1:0] LAST_IDX = ALU_CNT_W'(ALU_FRAME_BYTES - 1);

   ser_state_t           state_q;
   logic [ALU_CNT_W-1:0] cnt_q;
   res_frame_t           hold_q;
   res_frame_t           hold_d;
   logic [7:0]           sel_byte;
   logic                 out_valid;
   logic                 out_last;
   logic                 out_accept;
   logic                 res_ready;
   logic                 capture;

   assign out_valid  = (state_q == SEND);
   assign out_last   = out_valid && (cnt_q == LAST_IDX);
   assign out_accept = out_valid && ser_if.out_ready;
   assign res_ready  = (state_q == IDLE) || (out_accept && out_last);
   assign capture    = ser_if.res_valid && res_ready;

   assign hold_d.carry = ser_if.carry_q;
   assign hold_d.res   = ser_if.res_q;

   alu_res_byte_sel #(
      .LSB_FIRST (LSB_FIRST)
   ) u_byte_sel (
      .hold_i (hold_q),
      .cnt_i  (cnt_q),
      .byte_o (sel_byte)
   );

   assign ser_if.res_ready = res_ready;
   assign ser_if.out_valid = out_valid;
   assign ser_if.out_data  = out_valid ? sel_byte : 8'h00;
   assign ser_if.out_last  = out_last;
   assign ser_if.busy      = out_valid;
   assign dbg_state_o      = state_q;

   // Frame FSM: capture, advance the byte counter on each accepted byte, chain or idle at the end.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         hold_q  <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (capture) begin
                  hold_q  <= hold_d;
                  cnt_q   <= '0;
                  state_q <= SEND;
               end
            end
            SEND: begin
               if (out_accept) begin
                  if (out_last) begin
                     cnt_q <= '0;
                     if (capture) begin
                        hold_q  <= hold_d;
                        state_q <= SEND;
                     end else begin
                        state_q <= IDLE;
                     end
                  end else begin
                     cnt_q <= cnt_q + 1'b1;
                  end
               end
            end
            default: begin
               state_q <= IDLE;
               cnt_q   <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_result_serializer.sv
// tb_alu_result_serializer: drives one result stream into an LSB-first and an
// MSB-first serializer in lockstep and scoreboards both byte streams.
module tb_alu_result_serializer;
   import alu_pkg::*;

   localparam int W = 9;  // {last, data}

   logic        clk;
   logic        rst;
   logic        res_valid;
   logic [17:0] res_q;
   logic        carry_q;
   logic        out_ready;
   logic        rand_en;
   ser_state_t  st_lsb;
   ser_state_t  st_msb;

   int checks;
   int failures;

   logic [W-1:0] exp_lsb_q[$];
   logic [W-1:0] exp_msb_q[$];

   alu_result_serializer_if if_lsb ();
   alu_result_serializer_if if_msb ();

   assign if_lsb.res_valid = res_valid;
   assign if_lsb.res_q     = res_q;
   assign if_lsb.carry_q   = carry_q;
   assign if_lsb.out_ready = out_ready;
   assign if_msb.res_valid = res_valid;
   assign if_msb.res_q     = res_q;
   assign if_msb.carry_q   = carry_q;
   assign if_msb.out_ready = out_ready;

   alu_result_serializer #(.LSB_FIRST(1'b1)) dut_lsb (
      .clk         (clk),
      .rst         (rst),
      .ser_if      (if_lsb),
      .dbg_state_o (st_lsb)
   );

   alu_result_serializer #(.LSB_FIRST(1'b0)) dut_msb (
      .clk         (clk),
      .rst         (rst),
      .ser_if      (if_msb),
      .dbg_state_o (st_msb)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- checking ----------------
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [7:0] model_byte(input logic [17:0] r, input logic c,
                                             input bit lsb, input int i);
      logic [7:0] b[4];
      b[0] = r[7:0];
      b[1] = r[15:8];
      b[2] = {5'b00000, c, r[17:16]};
      b[3] = b[0] ^ b[1] ^ b[2];
      if (i == 3) return b[3];
      return lsb ? b[i] : b[2-i];
   endfunction

   task automatic push_frame(input logic [17:0] r, input logic c);
      for (int i = 0; i < ALU_FRAME_BYTES; i++) begin
         exp_lsb_q.push_back({(i == ALU_FRAME_BYTES-1), model_byte(r, c, 1'b1, i)});
         exp_msb_q.push_back({(i == ALU_FRAME_BYTES-1), model_byte(r, c, 1'b0, i)});
      end
   endtask

   // ---------------- scoreboard monitor ----------------
   always @(negedge clk) begin
      if (!rst) begin
         if (if_lsb.out_valid && out_ready) begin
            if (exp_lsb_q.size() == 0) chk("lsb_unexpected_byte", 1, 0);
            else chk("lsb_byte", {if_lsb.out_last, if_lsb.out_data}, exp_lsb_q.pop_front());
         end else if (if_lsb.out_valid) begin
            if (exp_lsb_q.size() != 0)
               chk("lsb_stall_hold", {if_lsb.out_last, if_lsb.out_data}, exp_lsb_q[0]);
            chk("lsb_stall_res_ready", if_lsb.res_ready, 0);
         end
         if (if_msb.out_valid && out_ready) begin
            if (exp_msb_q.size() == 0) chk("msb_unexpected_byte", 1, 0);
            else chk("msb_byte", {if_msb.out_last, if_msb.out_data}, exp_msb_q.pop_front());
         end else if (if_msb.out_valid) begin
            if (exp_msb_q.size() != 0)
               chk("msb_stall_hold", {if_msb.out_last, if_msb.out_data}, exp_msb_q[0]);
         end
         if (res_valid && if_lsb.res_ready) push_frame(res_q, carry_q);
      end
   end

   // Random downstream backpressure during the random phase.
   always @(posedge clk) begin
      if (rand_en) begin
         #1;
         out_ready = ($urandom_range(0, 3) != 0);
      end
   end

   // ---------------- driver tasks ----------------
   // Present a result and hold it until it is captured; returns 1 ns after the capture edge.
   task automatic drive_res(input logic [17:0] r, input logic c, output int waited);
      bit got;
      got       = 1'b0;
      waited    = 0;
      res_valid = 1'b1;
      res_q     = r;
      carry_q   = c;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         waited++;
         if (if_lsb.res_ready) begin
            got = 1'b1;
            break;
         end
      end
      if (!got) chk("res_handshake_timeout", 0, 1);
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle();
      bit done;
      done = 1'b0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (!if_lsb.busy && !if_msb.busy) begin
            done = 1'b1;
            break;
         end
      end
      if (!done) chk("idle_timeout", 0, 1);
   endtask

   // ---------------- main sequence ----------------
   logic [7:0] lsb_tab[4];
   logic [7:0] msb_tab[4];
   int         w;

   initial begin
      lsb_tab = '{8'hCD, 8'hAB, 8'h06, 8'h60};
      msb_tab = '{8'h06, 8'hAB, 8'hCD, 8'h60};
      checks = 0; failures = 0;
      rst = 1'b1; res_valid = 1'b0; res_q = '0; carry_q = 1'b0;
      out_ready = 1'b1; rand_en = 1'b0;
      #1;
      chk("rst_out_valid", if_lsb.out_valid, 0);
      chk("rst_out_data", if_lsb.out_data, 8'h00);
      chk("rst_busy", if_lsb.busy, 0);
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_res_ready", if_lsb.res_ready, 1);
      chk("rst_out_last", if_lsb.out_last, 0);
      chk("rst_state", st_lsb, IDLE);

      // Single frame, out_ready high: consecutive bytes in both orders.
      drive_res(18'h2ABCD, 1'b1, w);
      res_valid = 1'b0;
      for (int k = 0; k < ALU_FRAME_BYTES; k++) begin
         @(negedge clk);
         chk("frame_valid", if_lsb.out_valid, 1);
         chk("frame_lsb_data", if_lsb.out_data, lsb_tab[k]);
         chk("frame_msb_data", if_msb.out_data, msb_tab[k]);
         chk("frame_last", if_lsb.out_last, (k == ALU_FRAME_BYTES-1));
      end
      @(negedge clk);
      chk("frame_end_idle", if_lsb.out_valid, 0);
      chk("idle_out_data", if_lsb.out_data, 8'h00);

      // Backpressure: 5-cycle stall on B1.
      drive_res(18'h2ABCD, 1'b1, w);
      res_valid = 1'b0;
      @(posedge clk);
      #1 out_ready = 1'b0;
      repeat (5) begin
         @(negedge clk);
         chk("stall_valid", if_lsb.out_valid, 1);
         chk("stall_data", if_lsb.out_data, 8'hAB);
         chk("stall_res_ready", if_lsb.res_ready, 0);
      end
      out_ready = 1'b1;
      wait_idle();

      // Back-to-back: second capture lands on the last-byte cycle of the first.
      drive_res(18'h00001, 1'b0, w);
      drive_res(18'h3FFFF, 1'b1, w);
      chk("b2b_wait_cycles", w, ALU_FRAME_BYTES);
      res_valid = 1'b0;
      for (int k = 0; k < ALU_FRAME_BYTES; k++) begin
         @(negedge clk);
         chk("b2b_no_gap", if_lsb.out_valid, 1);
      end
      wait_idle();

      // res_valid while busy with a different payload must be ignored.
      drive_res(18'h15555, 1'b0, w);
      res_valid = 1'b0;
      @(posedge clk);
      #1 out_ready = 1'b0;
      res_valid = 1'b1; res_q = 18'h3F0F0; carry_q = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("busy_no_ready", if_lsb.res_ready, 0);
      end
      @(posedge clk);
      #1 res_valid = 1'b0;
      out_ready = 1'b1;
      wait_idle();

      // Random results with random backpressure.
      rand_en = 1'b1;
      for (int n = 0; n < 12; n++) begin
         drive_res(18'($urandom_range(0, 18'h3FFFF)), 1'($urandom_range(0, 1)), w);
         if ($urandom_range(0, 1) != 0) begin
            res_valid = 1'b0;
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
         end
      end
      res_valid = 1'b0;
      rand_en = 1'b0;
      @(posedge clk);
      #2 out_ready = 1'b1;
      wait_idle();

      // Asynchronous reset while B1 is pending.
      drive_res(18'h2ABCD, 1'b1, w);
      res_valid = 1'b0;
      @(posedge clk);
      #1 out_ready = 1'b0;
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("midrst_out_valid", if_lsb.out_valid, 0);
      chk("midrst_busy", if_lsb.busy, 0);
      chk("midrst_out_data", if_msb.out_data, 8'h00);
      exp_lsb_q.delete();
      exp_msb_q.delete();
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("postrst_res_ready", if_lsb.res_ready, 1);
      chk("postrst_state", st_msb, IDLE);
      out_ready = 1'b1;
      drive_res(18'h12345, 1'b0, w);
      res_valid = 1'b0;
      @(negedge clk);
      chk("postrst_first_lsb", if_lsb.out_data, 8'h45);
      chk("postrst_first_msb", if_msb.out_data, 8'h01);
      wait_idle();

      chk("drain_lsb", exp_lsb_q.size(), 0);
      chk("drain_msb", exp_msb_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
